// File: rtl/data_memory_line_if.sv
// Request/response bundle between the data cache refill port and the line memory.
// The requester drives enable/write/addr/data_i; the memory returns ack_o and data_o.
interface data_memory_line_if #(
  parameter int LINE_W = 256
);
  logic              enable_i;
  logic              write_i;
  logic [31:0]       addr_i;
  logic [LINE_W-1:0] data_i;
  logic              ack_o;
  logic [LINE_W-1:0] data_o;

  modport master (
    output enable_i, write_i, addr_i, data_i,
    input  ack_o, data_o
  );

  modport slave (
    input  enable_i, write_i, addr_i, data_i,
    output ack_o, data_o
  );
endinterface

// File: rtl/data_memory_line.sv
// Line-wide backing memory modelling DRAM: one request at a time, ack_o pulses in the LATENCY-th
// cycle after the accept edge; the requester holds enable_i until ack_o, and inputs are ignored while busy.
module data_memory_line #(
  parameter int LINE_W  = 256,
  parameter int IDX_W   = 9,
  parameter int LATENCY = 10
) (
  input  logic               clk_i,
  input  logic               rst_i,
  data_memory_line_if.slave  bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_ACK  = 2'd2;
  localparam logic [7:0] CNT_LAST = 8'(LATENCY - 1);

  logic [1:0]        state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              wr_q, wr_d;
  logic [LINE_W-1:0] wdat_q, wdat_d;
  logic              ack_q, ack_d;
  logic [LINE_W-1:0] rdat_q, rdat_d;
  logic              commit_wr;

  logic [LINE_W-1:0] mem [2**IDX_W];
  logic [LINE_W-1:0] rd_line;

  // Offset bits and high bits beyond the depth are dropped, so indices alias by design.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.addr_i[31:IDX_W+5], bus.addr_i[4:0]};

  assign rd_line = mem[idx_q];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    wr_d      = wr_q;
    wdat_d    = wdat_q;
    ack_d     = 1'b0;
    rdat_d    = '0;
    commit_wr = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.enable_i) begin
          idx_d   = bus.addr_i[IDX_W+4:5];
          wr_d    = bus.write_i;
          wdat_d  = bus.data_i;
          cnt_d   = 8'd1;
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        cnt_d = cnt_q + 8'd1;
        if (cnt_q == CNT_LAST) begin
          // The array is only touched on this edge, so a reset while busy leaves it intact.
          state_d = S_ACK;
          ack_d   = 1'b1;
          if (wr_q) begin
            commit_wr = 1'b1;
          end else begin
            rdat_d = rd_line;
          end
        end
      end
      S_ACK: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      wr_q    <= 1'b0;
      wdat_q  <= '0;
      ack_q   <= 1'b0;
      rdat_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wr_q    <= wr_d;
      wdat_q  <= wdat_d;
      ack_q   <= ack_d;
      rdat_q  <= rdat_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (commit_wr) begin
      mem[idx_q] <= wdat_q;
    end
  end

  assign bus.ack_o  = ack_q;
  assign bus.data_o = rdat_q;

endmodule

// File: tb/tb_data_memory_line.sv
// Scoreboard bench for data_memory_line: requests push the expected ack cycle and data,
// a negedge monitor pops on every ack and checks data_o is zero on all other cycles.
module tb_data_memory_line;
  localparam int L  = 10;
  localparam int LW = 256;

  typedef struct {
    int            cyc;
    logic [LW-1:0] dat;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_i = 1'b1;
  int   cyc   = 0;
  int   n_vec = 0;
  int   n_bad = 0;
  int   n_ack = 0;
  exp_t sb[$];

  data_memory_line_if #(.LINE_W(LW)) bus();

  data_memory_line #(.LINE_W(LW), .IDX_W(9), .LATENCY(L)) dut (
    .clk_i (clk),
    .rst_i (rst_i),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Cycle k after the accept edge carries cyc == accept_cyc + k - 1; ack belongs in cycle L.
  always @(negedge clk) begin
    exp_t e;
    n_vec++;
    if (bus.ack_o === 1'b1) begin
      n_ack++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_ack cyc=%0d data_o=%h", cyc, bus.data_o);
      end else begin
        e = sb.pop_front();
        if (cyc != e.cyc || bus.data_o !== e.dat) begin
          n_bad++;
          $display("FAIL ack_response got cyc=%0d data=%h want cyc=%0d data=%h",
                   cyc, bus.data_o, e.cyc, e.dat);
        end
      end
    end else if (bus.ack_o !== 1'b0 || bus.data_o !== '0) begin
      n_bad++;
      $display("FAIL idle_outputs cyc=%0d ack=%b data_o=%h want ack=0 data_o=0",
               cyc, bus.ack_o, bus.data_o);
    end
  end

  task automatic push_exp(input int c, input logic [LW-1:0] d);
    exp_t e;
    e.cyc = c;
    e.dat = d;
    sb.push_back(e);
  endtask

  task automatic drive(input bit wr, input logic [31:0] a, input logic [LW-1:0] d);
    bus.enable_i = 1'b1;
    bus.write_i  = wr;
    bus.addr_i   = a;
    bus.data_i   = d;
  endtask

  task automatic wait_ack();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (bus.ack_o === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_vec++;
      n_bad++;
      $display("FAIL ack_timeout cyc=%0d got no ack want ack within 60 cycles", cyc);
    end
  endtask

  task automatic xfer(input bit wr, input logic [31:0] a, input logic [LW-1:0] d,
                      input logic [LW-1:0] exp_d);
    @(negedge clk);
    drive(wr, a, d);
    push_exp(cyc + L, exp_d);
    wait_ack();
    bus.enable_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d bench did not finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int ack_before;
    int acc;
    bus.enable_i = 1'b0;
    bus.write_i  = 1'b0;
    bus.addr_i   = '0;
    bus.data_i   = '0;
    #1 rst_i = 1'b0;
    repeat (3) @(negedge clk);
    rst_i = 1'b1;
    repeat (20) @(negedge clk);

    // Preload through the port.
    xfer(1'b1, 32'h0000_00A0, {32{8'hA5}}, '0);
    xfer(1'b1, 32'h0000_0020, {16{16'h1111}}, '0);
    xfer(1'b1, 32'h0000_3FE0, {16{16'h55FF}}, '0);
    xfer(1'b1, 32'h0000_0060, {16{16'h3333}}, '0);

    // Read latency; garbage offset bits must be ignored.
    xfer(1'b0, 32'h0000_00A0, '1, {32{8'hA5}});
    xfer(1'b0, 32'h0000_00BF, '1, {32{8'hA5}});

    // Write then read.
    xfer(1'b1, 32'h0000_0040, {4{64'h0123_4567_89AB_CDEF}}, '0);
    xfer(1'b0, 32'h0000_0040, '0, {4{64'h0123_4567_89AB_CDEF}});

    // Back-to-back, enable held high through ACK: accepts L+1 cycles apart.
    @(negedge clk);
    drive(1'b0, 32'h0000_0020, '0);
    acc = cyc + 1;
    push_exp(acc + L - 1, {16{16'h1111}});
    push_exp(acc + 2 * L, {16{16'h55FF}});
    wait_ack();
    bus.addr_i = 32'h0000_3FE0;
    wait_ack();
    bus.enable_i = 1'b0;

    // Reset in cycle 4 of BUSY: no ack and no commit.
    @(negedge clk);
    ack_before = n_ack;
    drive(1'b1, 32'h0000_0060, 256'h1);
    repeat (4) @(negedge clk);
    rst_i = 1'b0;
    bus.enable_i = 1'b0;
    repeat (2) @(negedge clk);
    rst_i = 1'b1;
    repeat (L + 5) @(negedge clk);
    n_vec++;
    if (n_ack != ack_before) begin
      n_bad++;
      $display("FAIL reset_abort_ack got %0d acks want 0", n_ack - ack_before);
    end
    xfer(1'b0, 32'h0000_0060, '0, {16{16'h3333}});

    // enable_i dropped in cycle 3 of BUSY: the write still completes.
    @(negedge clk);
    drive(1'b1, 32'h0000_0060, 256'h1);
    push_exp(cyc + L, '0);
    repeat (3) @(negedge clk);
    bus.enable_i = 1'b0;
    bus.data_i   = '1;
    wait_ack();
    xfer(1'b0, 32'h0000_0060, '0, 256'h1);

    // Index 513 aliases to 1.
    xfer(1'b1, 32'h0000_4020, 256'hFF, '0);
    xfer(1'b0, 32'h0000_0020, '0, 256'hFF);
    xfer(1'b0, 32'h0000_3FE0, '0, {16{16'h55FF}});

    repeat (5) @(negedge clk);
    n_vec++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain got %0d pending want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/data_memory_line.md
Name: data_memory_line

Overview:
- Line-granular backing data memory serving the data cache's refill/write-back port: `mem_enable`, `mem_write`, `mem_addr`, 256-bit `mem_data` in both directions, and `mem_ack`.
- Sits directly downstream of the CPU top-level `mem_*` ports.
- Models off-chip DRAM with a fixed, parameterised access latency.
- One request at a time; completion is signalled by a single-cycle ack pulse.

Parameters:
- LINE_W, 256, line width in bits (must match the cache line).
- IDX_W, 9, line index width; depth = 2**IDX_W lines (16 KiB default).
- LATENCY, 10, cycles from the accept edge to ack_o high; legal range 2..255.

Ports:
- clk_i  input  1  clock, all state on rising edge.
- rst_i  input  1  reset, asynchronous, active-low.
- enable_i  input  1  request valid; held high by the requester until ack_o.
- write_i  input  1  1 = write line, 0 = read line; sampled at accept.
- addr_i  input  32  byte address; bits [4:0] ignored; line index = addr_i[IDX_W+4:5].
- data_i  input  LINE_W  write data; sampled at accept.
- ack_o  output  1  one-cycle completion pulse.
- data_o  output  LINE_W  read data; valid only while ack_o=1, else all zeros.

Behaviour:
- States: IDLE, BUSY, ACK. A counter cnt of 8 bits is used.
- Reset (rst_i=0, asynchronous): state=IDLE, cnt=0, ack_o=0, data_o=0. The array is not reset; the bench preloads it.
- IDLE:
  - If enable_i=1 at a rising edge, accept the request.
  - Latch idx, write_i and data_i into request registers.
  - Set cnt=1 and go to BUSY.
  - If enable_i=0, stay in IDLE.
- BUSY:
  - Increment cnt each edge.
  - When cnt==LATENCY-1, go to ACK on the next edge.
  - On the transition edge:
    - if latched write: mem[idx] <= latched data; data_o stays 0.
    - if latched read: data_o <= mem[idx].
- ACK:
  - ack_o=1 for exactly one cycle; then go to IDLE, ack_o=0, data_o=0.
  - ack_o therefore rises exactly LATENCY cycles after the accept edge.
- ack_o and data_o are registered outputs; there is no combinational path from any input to any output.
- Inputs are ignored in BUSY and ACK. Changes to addr_i, data_i or write_i after accept have no effect.
- Deassertion of enable_i during BUSY does not abort the request: the write still commits and ack_o still pulses. Requesters must not rely on cancellation.
- Back-to-back: the ACK cycle is never an accept cycle. A request held high through ACK is accepted at the IDLE edge after it.
  - Minimum spacing between accept edges is therefore LATENCY+1 cycles.
- Reset asserted in BUSY:
  - Return to IDLE immediately; no ack is produced.
  - A pending write is not committed, because the commit only occurs on the BUSY->ACK edge.
- Reset asserted during ACK: the write already committed stays committed; ack_o drops immediately.
- Address wrap: indices beyond the depth alias modulo 2**IDX_W through the bit-slice. No error is reported.
- Read-after-write to the same line in the next request returns the new data.
- X on enable_i while in IDLE is a bench error. The RTL is not required to handle it.

Test Plan:
- Reset then idle: rst_i low 3 cycles then high, enable_i=0 for 20 cycles -> ack_o=0, data_o=0 throughout.
- Read latency: preload mem[5]=256'hA5...A5; request enable_i=1, write_i=0, addr_i=32'h000000A0 -> ack_o high exactly 10 cycles after the accept edge for 1 cycle, data_o=A5...A5 that cycle, 0 before and after.
- Write then read: write 256'h0123...CDEF to addr 32'h00000040 and wait for ack, then read the same addr -> the second ack returns 0123...CDEF; the write's ack cycle shows data_o=0.
- Back-to-back with enable_i held high: two reads of addr 0x20 and 0x3FE0 -> accept edges 11 cycles apart, two single-cycle acks, correct data for each.
- Mid-operation disturbance:
  - write to 0x60 with data 256'h1, reset pulsed at cycle 4 of BUSY -> no ack, mem[3] unchanged (verified by a subsequent read).
  - separate run: enable_i dropped at cycle 3 -> ack still at cycle 10 and mem[3]=1.
- Wrap-around: write 256'hFF to addr 32'h00004020 (index 513 mod 512 = 1) -> a read of addr 32'h00000020 returns 256'hFF.
